// File: rtl/lab3_pkg.sv
// Shared definitions for the Lab 3 input conditioner.
//   - MODE_* : 2-bit lighting mode encodings consumed by the tail-light controller
//   - DEBOUNCE_CYCLES_DEFAULT : 20 ms of stability at 10 MHz
//   - select_mode() : priority encoder from conditioned inputs to a lighting mode
package lab3_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 200000;

    localparam logic [1:0] MODE_OFF        = 2'b00;
    localparam logic [1:0] MODE_HAZARD     = 2'b01;
    localparam logic [1:0] MODE_TURN_LEFT  = 2'b10;
    localparam logic [1:0] MODE_TURN_RIGHT = 2'b11;

    // Halt wins over everything; hazard (SW0) wins over turn (SW1); any other
    // switch combination on its own lights nothing.
    function automatic logic [1:0] select_mode(
        input logic halt_v,
        input logic any_sw,
        input logic sw_hazard,
        input logic sw_turn,
        input logic turn_left
    );
        logic [1:0] m;
        if (halt_v) begin
            m = MODE_OFF;
        end else if (!any_sw) begin
            m = MODE_OFF;
        end else if (sw_hazard) begin
            m = MODE_HAZARD;
        end else if (sw_turn) begin
            m = turn_left ? MODE_TURN_LEFT : MODE_TURN_RIGHT;
        end else begin
            m = MODE_OFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One-bit synchroniser + debouncer.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   raw    : asynchronous input bit (raw polarity)
//   stable : debounced level (raw polarity), resets to RESET_VAL
// The stable value only follows the synchronised input after it has differed
// for DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
module debounce_cell
    import lab3_pkg::*;
#(
    parameter logic RESET_VAL       = 1'b0,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-flop synchroniser, stability counter and debounced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= RESET_VAL;
            sync2_r <= RESET_VAL;
            cnt_r   <= CNT_W'(0);
            stable  <= RESET_VAL;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r != stable) begin
                if (cnt_r == CNT_MAX) begin
                    stable <= sync2_r;
                    cnt_r  <= CNT_W'(0);
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= CNT_W'(0);
            end
        end
    end

endmodule

// File: rtl/lab3_input_conditioner.sv
// Input conditioner for the Lab 3 tail-light controller.
//   ADC_CLK_10 : 10 MHz system clock
//   rst        : synchronous active-high reset
//   KEY[1:0]   : raw pushbuttons, 0 = pressed
//   SW         : raw slide switches, 1 = on
//   key_level  : debounced key state, 1 = pressed
//   key_press  : one-cycle pulse per debounced press
//   sw_clean   : debounced switch levels
//   halt       : toggles on each KEY0 press
//   turn_dir   : toggles on each KEY1 press (1 = left, 0 = right)
//   mode       : registered lighting mode (see lab3_pkg MODE_*)
module lab3_input_conditioner
    import lab3_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int NUM_SW          = 10
) (
    input  logic              ADC_CLK_10,
    input  logic              rst,
    input  logic [1:0]        KEY,
    input  logic [NUM_SW-1:0] SW,
    output logic [1:0]        key_level,
    output logic [1:0]        key_press,
    output logic [NUM_SW-1:0] sw_clean,
    output logic              halt,
    output logic              turn_dir,
    output logic [1:0]        mode
);

    // Keys are debounced in raw polarity (released = 1) so the cells reset to
    // "released"; the inversion to active-high happens on the stable output.
    logic [1:0] key_stable_s;
    logic [1:0] key_level_d_r;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            debounce_cell #(
                .RESET_VAL       (1'b1),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_key (
                .clk    (ADC_CLK_10),
                .rst    (rst),
                .raw    (KEY[gi]),
                .stable (key_stable_s[gi])
            );
        end
        for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
            debounce_cell #(
                .RESET_VAL       (1'b0),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_sw (
                .clk    (ADC_CLK_10),
                .rst    (rst),
                .raw    (SW[gi]),
                .stable (sw_clean[gi])
            );
        end
    endgenerate

    assign key_level = ~key_stable_s;

    // Rising-edge detect on the debounced keys, toggle state and mode encoding.
    always_ff @(posedge ADC_CLK_10) begin
        if (rst) begin
            key_level_d_r <= 2'b00;
            key_press     <= 2'b00;
            halt          <= 1'b0;
            turn_dir      <= 1'b0;
            mode          <= MODE_OFF;
        end else begin
            key_level_d_r <= key_level;
            key_press     <= key_level & ~key_level_d_r;
            halt          <= halt ^ key_press[0];
            turn_dir      <= turn_dir ^ key_press[1];
            mode          <= select_mode(halt, |sw_clean, sw_clean[0], sw_clean[1], turn_dir);
        end
    end

endmodule

// File: tb/tb_lab3_input_conditioner.sv
// Directed self-checking bench for lab3_input_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lab3_input_conditioner;

    localparam int NUM_SW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        KEY;
    logic [NUM_SW-1:0] SW;
    logic [1:0]        key_level;
    logic [1:0]        key_press;
    logic [NUM_SW-1:0] sw_clean;
    logic              halt;
    logic              turn_dir;
    logic [1:0]        mode;

    int errors = 0;
    int checks = 0;
    int p0 = 0;
    int p1 = 0;
    int kl1_seen = 0;

    lab3_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .NUM_SW          (NUM_SW)
    ) dut (
        .ADC_CLK_10 (clk),
        .rst        (rst),
        .KEY        (KEY),
        .SW         (SW),
        .key_level  (key_level),
        .key_press  (key_press),
        .sw_clean   (sw_clean),
        .halt       (halt),
        .turn_dir   (turn_dir),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {16'h0000, key_level, key_press, sw_clean, halt, turn_dir, mode}, 32'h0000_0000);
    endtask

    // Advance n clocks, sampling on each falling edge and tallying press pulses.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (key_press[0] === 1'b1) p0++;
            if (key_press[1] === 1'b1) p1++;
            if (key_level[1] === 1'b1) kl1_seen++;
        end
    endtask

    initial begin
        rst = 1'b1;
        KEY = 2'b11;
        SW  = 10'h000;
        @(negedge clk);
        step(2);
        chk_zero("reset");

        // Idle for 20 cycles: everything stays at zero.
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk_zero("idle");
        end

        // KEY0 press: level after 6 clocks, pulse on the 7th, halt on the 8th.
        p0 = 0;
        KEY = 2'b10;
        step(5);
        chk("kl0_early", key_level, 2'b00);
        step(1);
        chk("kl0_rise", key_level, 2'b01);
        chk("kp0_not_yet", key_press, 2'b00);
        step(1);
        chk("kp0_pulse", key_press, 2'b01);
        chk("halt_not_yet", halt, 1'b0);
        step(1);
        chk("kp0_one_cycle", key_press, 2'b00);
        chk("halt_set", halt, 1'b1);
        chk("mode_halt_off", mode, 2'b00);

        // Release produces no pulse; a second press clears halt.
        p0 = 0;
        KEY = 2'b11;
        step(10);
        chk("release_no_pulse", p0, 0);
        chk("kl0_released", key_level, 2'b00);
        chk("halt_held", halt, 1'b1);
        KEY = 2'b10;
        step(10);
        chk("second_press_cnt", p0, 1);
        chk("halt_cleared", halt, 1'b0);
        KEY = 2'b11;
        step(10);

        // KEY1 bounce shorter than the debounce window: nothing happens.
        p1 = 0;
        kl1_seen = 0;
        KEY = 2'b01; step(3);
        KEY = 2'b11; step(1);
        KEY = 2'b01; step(3);
        KEY = 2'b11; step(10);
        chk("bounce_no_level", kl1_seen, 0);
        chk("bounce_no_press", p1, 0);
        chk("bounce_turn_dir", turn_dir, 1'b0);

        // KEY1 held long enough: one press, turn_dir 0->1.
        KEY = 2'b01;
        step(10);
        chk("kp1_cnt", p1, 1);
        chk("turn_dir_set", turn_dir, 1'b1);
        chk("kl1_held", key_level, 2'b10);
        KEY = 2'b11;
        step(10);

        // Another KEY1 press returns turn_dir to right.
        KEY = 2'b01; step(10);
        KEY = 2'b11; step(10);
        chk("turn_dir_back", turn_dir, 1'b0);

        // Mode priority.
        SW = 10'h003; step(8);
        chk("sw_clean_003", sw_clean, 10'h003);
        chk("mode_hazard", mode, 2'b01);
        SW = 10'h002; step(8);
        chk("mode_turn_right", mode, 2'b11);
        KEY = 2'b01; step(10);
        chk("turn_dir_left", turn_dir, 1'b1);
        chk("mode_turn_left", mode, 2'b10);
        KEY = 2'b11; step(10);
        SW = 10'h200; step(8);
        chk("sw_clean_200", sw_clean, 10'h200);
        chk("mode_other_off", mode, 2'b00);
        SW = 10'h002; step(8);
        chk("mode_left_again", mode, 2'b10);

        // Both keys on the same edge.
        p0 = 0;
        p1 = 0;
        KEY = 2'b00;
        step(6);
        chk("both_level", key_level, 2'b11);
        step(1);
        chk("both_press", key_press, 2'b11);
        chk("mode_before_flip", mode, 2'b10);
        step(1);
        chk("both_halt", halt, 1'b1);
        chk("both_turn_dir", turn_dir, 1'b0);
        chk("mode_lags_one", mode, 2'b10);
        step(1);
        chk("both_mode_off", mode, 2'b00);
        KEY = 2'b11;
        step(10);
        chk("both_p0", p0, 1);
        chk("both_p1", p1, 1);

        // Reset in the middle of a KEY0 count; key held through reset.
        KEY = 2'b10;
        step(4);
        rst = 1'b1;
        step(1);
        chk_zero("rst_mid_1");
        step(1);
        chk_zero("rst_mid_2");
        rst = 1'b0;
        p0 = 0;
        step(5);
        chk("post_rst_early", key_level, 2'b00);
        step(1);
        chk("post_rst_level", key_level, 2'b01);
        step(1);
        chk("post_rst_press", key_press, 2'b01);
        chk("post_rst_mode_right", mode, 2'b11);
        step(1);
        chk("post_rst_halt", halt, 1'b1);
        step(1);
        chk("post_rst_mode_off", mode, 2'b00);
        KEY = 2'b11;
        step(10);
        chk("post_rst_one_press", p0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lab3_input_conditioner.md
Name: lab3_input_conditioner

Overview:
Input-side companion to the Lab 3 tail-light controller. It takes the raw board pushbuttons (KEY, active-low) and slide switches (SW) and synchronises and debounces them. It then produces clean levels, one-cycle press events and the two toggle states the controller consumes: halt (KEY0) and turn direction (KEY1). It also encodes a registered 2-bit lighting mode, so the controller can run on one clock with no edge-triggered logic on KEY.

Parameters:
DEBOUNCE_CYCLES, 200000, consecutive clocks an input must differ from its stable value before the stable value updates (20 ms at 10 MHz); minimum 2
NUM_SW, 10, number of slide switches conditioned
CNT_W, $clog2(DEBOUNCE_CYCLES), width of each debounce counter (derived, not overridden)

Ports:
ADC_CLK_10  in   1       single system clock, 10 MHz
rst         in   1       synchronous, active-high reset
KEY         in   2       raw pushbuttons, asynchronous, 0 = pressed
SW          in   NUM_SW  raw slide switches, asynchronous, 1 = on
key_level   out  2       debounced key state, 1 = pressed
key_press   out  2       one-cycle pulse per debounced press
sw_clean    out  NUM_SW  debounced switch levels
halt        out  1       toggles on each key_press[0]
turn_dir    out  1       toggles on each key_press[1]; 1 = left, 0 = right
mode        out  2       registered lighting mode: 00 OFF, 01 HAZARD, 10 TURN_LEFT, 11 TURN_RIGHT

Behaviour:
- All state is updated on posedge ADC_CLK_10 only. rst is sampled synchronously and overrides everything else.
- Reset values:
  - KEY synchroniser flops = 1 (released); SW synchroniser flops = 0.
  - All counters = 0; key_level = 0; key_press = 0; sw_clean = 0.
  - halt = 0; turn_dir = 0; mode = 00.
- Synchroniser: two flops per bit. KEY is inverted after synchronisation, so all internal logic is active-high.
- Debounce, per bit:
  - If synced != stable, the counter increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and synced still differs, stable <= synced and counter <= 0.
  - If synced == stable, counter <= 0. Any bounce therefore restarts the count.
- Latency: a raw change held steady is reflected on key_level/sw_clean exactly DEBOUNCE_CYCLES+2 clocks after the first edge that samples it.
- key_press[i]:
  - Registered.
  - High for exactly one cycle, the cycle after key_level[i] goes 0->1.
  - Releases generate no pulse.
  - Press and release glitches shorter than DEBOUNCE_CYCLES generate nothing.
- halt and turn_dir each flip on their key_press. If both keys press in the same cycle, both flip in that cycle.
- mode is registered and updates one cycle after its inputs change. Priority, highest first:
  1. halt = 1 -> OFF
  2. sw_clean all zero -> OFF
  3. sw_clean[0] = 1 -> HAZARD
  4. sw_clean[1] = 1 -> TURN_LEFT if turn_dir = 1, else TURN_RIGHT
  5. any other switch only -> OFF
- Reset mid-debounce: the partial count is discarded.
- Key held through reset release: it is re-debounced from released state, so it produces one key_press DEBOUNCE_CYCLES+2 (+1) cycles after rst deasserts. This is intended; the held key is treated as a fresh press.
- Counter width: CNT_W bits. The counter never exceeds DEBOUNCE_CYCLES-1, so no wrap occurs.

Decomposition:
- Shared package lab3_pkg holds:
  - mode encodings MODE_OFF, MODE_HAZARD, MODE_TURN_LEFT, MODE_TURN_RIGHT
  - DEBOUNCE_CYCLES default
- Sub-module debounce_cell covers one bit: 2-flop sync, counter and stable register.
  - Parameters: RESET_VAL (stable/sync reset value) and DEBOUNCE_CYCLES.
  - Instantiated 2 + NUM_SW times.
- Top level holds the press-edge, toggle and mode logic.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset, then all inputs idle (KEY=2'b11, SW=0) for 20 cycles -> every output 0, mode = 00 throughout.
- KEY[0] driven low and held -> key_level[0] rises exactly 6 cycles later, key_press[0] pulses for 1 cycle the next cycle, halt = 1 after that. Release and press again -> halt = 0.
- KEY[1] bounce: low 3 cycles, high 1, low 3, high -> no key_level, no key_press, turn_dir unchanged. Then low held for 10 cycles -> one press, turn_dir 0->1.
- SW = 10'b00_0000_0011, turn_dir = 0 -> mode = 01 (HAZARD has priority). SW = 10'b00_0000_0010 -> mode = 11. Press KEY1 -> mode = 10. SW = 10'b10_0000_0000 -> mode = 00.
- Both KEYs go low on the same edge -> both key_press bits pulse in the same cycle, halt and turn_dir flip together, mode = 00 because halt = 1.
- Hold KEY[0] low, assert rst for 2 cycles mid-count at count 2, deassert with KEY still low -> all outputs 0 during reset, key_level[0] rises 6 cycles after rst drops, one key_press[0], halt = 1.
